// File: rtl/fifo_to_axis_pkg.sv
// Shared definitions for the replay FIFO drain path: half-word layout,
// tuser field offsets, FSM encoding and the per-cycle step record.
package fifo_to_axis_pkg;

    localparam int HALF_W       = 36;
    localparam int VALID_BIT    = 35;
    localparam int EOP_BIT      = 34;
    localparam int BCNT_HI      = 33;
    localparam int BCNT_LO      = 32;
    localparam int TUSER_SRC_LO = 16;
    localparam int TUSER_DST_LO = 24;
    localparam int BEAT_CNT_W   = 16;

    typedef logic [HALF_W-1:0] half_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Outcome of walking residue + (optionally) one FIFO word for one cycle.
    typedef struct packed {
        logic                  ok;        // all halves fit: one beat + one residue
        logic                  beat;      // a beat is produced
        logic                  tlast;     // beat closes the packet (eop or forced)
        logic                  forced;    // beat was truncated at the length cap
        logic                  beat_new;  // the beat's packet opened this cycle
        logic                  pkt_new;   // some packet opened this cycle
        logic                  rest_vld;  // a half is left for the residue
        half_t                 rest;
        half_t                 slot0;     // lanes [31:0]
        half_t                 slot1;     // lanes [63:32]
        state_t                state;
        logic [BEAT_CNT_W-1:0] cnt;
    } step_t;

endpackage

// File: rtl/fifo_to_axis_half_keep_gen.sv
// Byte-enable generator for one 32-bit lane group of an output beat.
module half_keep_gen (
    input  logic       valid,
    input  logic       eop,
    input  logic [1:0] bcnt,
    output logic [3:0] keep
);

    // Full halves enable all four lanes; an eop half enables bcnt+1 low lanes.
    always_comb begin
        keep = 4'h0;
        if (valid) begin
            if (!eop) begin
                keep = 4'hF;
            end else begin
                case (bcnt)
                    2'd0:    keep = 4'b0001;
                    2'd1:    keep = 4'b0011;
                    2'd2:    keep = 4'b0111;
                    default: keep = 4'b1111;
                endcase
            end
        end
    end

endmodule

// File: rtl/fifo_to_axis.sv
// Drains the 72-bit replay FIFO (two 36-bit halves per word) into a 64-bit
// AXI4-Stream, dropping padding halves, realigning packets through a one-half
// residue register and truncating packets that exceed the beat cap.
module fifo_to_axis
    import fifo_to_axis_pkg::*;
#(
    parameter int         C_FIFO_DATA_WIDTH    = 72,
    parameter int         C_M_AXIS_DATA_WIDTH  = 64,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0] C_SRC_PORT           = 8'h00,
    parameter int         C_MAX_BEATS          = 190
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sw_rst,
    input  logic [C_FIFO_DATA_WIDTH-1:0]      fifo_dout,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic [7:0]                        sw_dst_port,
    output logic [31:0]                       pkt_count,
    output logic                              err_oversize
);

    localparam int NLANES = C_M_AXIS_DATA_WIDTH / 8;

    state_t                            state_q, state_d;
    logic [BEAT_CNT_W-1:0]             cnt_q, cnt_d;
    logic                              res_vld_q, res_vld_d;
    half_t                             res_q, res_d;
    logic [7:0]                        dst_q, dst_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic [NLANES-1:0]                 tkeep_q, tkeep_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
    logic                              tvalid_q, tvalid_d;
    logic                              tlast_q, tlast_d;
    logic [31:0]                       pkt_count_q, pkt_count_d;
    logic                              err_q, err_d;

    step_t                             step_w, step_r, sel;
    logic                              load_ok, pop;
    logic [3:0]                        keep_lo, keep_hi;
    logic [NLANES-1:0]                 beat_keep;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    beat_data;

    // Walk residue, low half, high half in order and describe what they produce.
    function automatic step_t step(input state_t                         st_in,
                                   input logic [BEAT_CNT_W-1:0]          cnt_in,
                                   input logic                           rv,
                                   input half_t                          res,
                                   input logic                           use_word,
                                   input logic [C_FIFO_DATA_WIDTH-1:0]   word);
        step_t      r;
        half_t      h [3];
        logic       done;
        logic [1:0] nslots;
        r        = '0;
        r.ok     = 1'b1;
        r.state  = st_in;
        r.cnt    = cnt_in;
        done     = 1'b0;
        nslots   = 2'd0;
        h[0]     = rv ? res : '0;
        h[1]     = use_word ? word[HALF_W-1:0] : '0;
        h[2]     = use_word ? word[2*HALF_W-1:HALF_W] : '0;
        // A held eop half always leaves on its own beat before any new word.
        if (use_word && rv && res[EOP_BIT]) r.ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (h[i][VALID_BIT]) begin
                if (r.state == ST_DROP) begin
                    if (h[i][EOP_BIT]) r.state = ST_IDLE;
                end else if (done) begin
                    if (r.rest_vld) r.ok = 1'b0;
                    r.rest_vld = 1'b1;
                    r.rest     = h[i];
                    if (r.state == ST_IDLE) begin
                        r.state   = ST_PKT;
                        r.pkt_new = 1'b1;
                    end
                end else begin
                    if (r.state == ST_IDLE) begin
                        r.state    = ST_PKT;
                        r.pkt_new  = 1'b1;
                        r.beat_new = 1'b1;
                    end
                    if (nslots == 2'd0) begin
                        r.slot0 = h[i];
                        nslots  = 2'd1;
                    end else begin
                        r.slot1 = h[i];
                        nslots  = 2'd2;
                    end
                    if (h[i][EOP_BIT] || nslots == 2'd2) begin
                        done    = 1'b1;
                        r.beat  = 1'b1;
                        r.tlast = h[i][EOP_BIT];
                        if (h[i][EOP_BIT]) begin
                            r.state = ST_IDLE;
                            r.cnt   = '0;
                        end else if (r.cnt == BEAT_CNT_W'(C_MAX_BEATS - 1)) begin
                            r.tlast  = 1'b1;
                            r.forced = 1'b1;
                            r.state  = ST_DROP;
                            r.cnt    = '0;
                        end else begin
                            r.cnt = r.cnt + 1'b1;
                        end
                    end
                end
            end
        end
        // A lone non-eop half waits in the residue for its partner.
        if (!done && nslots == 2'd1) begin
            r.rest_vld = 1'b1;
            r.rest     = r.slot0;
            r.slot0    = '0;
        end
        return r;
    endfunction

    // Decide whether the FIFO head can be consumed this cycle.
    always_comb begin
        load_ok = !tvalid_q || m_axis_tready;
        step_w  = step(state_q, cnt_q, res_vld_q, res_q, 1'b1, fifo_dout);
        step_r  = step(state_q, cnt_q, res_vld_q, res_q, 1'b0, fifo_dout);
        pop     = load_ok && !fifo_empty && step_w.ok && !sw_rst;
        sel     = pop ? step_w : step_r;
    end

    half_keep_gen u_keep_lo (
        .valid (sel.slot0[VALID_BIT]),
        .eop   (sel.slot0[EOP_BIT]),
        .bcnt  (sel.slot0[BCNT_HI:BCNT_LO]),
        .keep  (keep_lo)
    );

    half_keep_gen u_keep_hi (
        .valid (sel.slot1[VALID_BIT]),
        .eop   (sel.slot1[EOP_BIT]),
        .bcnt  (sel.slot1[BCNT_HI:BCNT_LO]),
        .keep  (keep_hi)
    );

    assign beat_keep = {keep_hi, keep_lo};

    // Unused lanes carry zero data.
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        if (gi < 4) begin : g_lo
            assign beat_data[8*gi +: 8] = beat_keep[gi] ? sel.slot0[8*gi +: 8] : 8'h00;
        end else begin : g_hi
            assign beat_data[8*gi +: 8] = beat_keep[gi] ? sel.slot1[8*(gi-4) +: 8] : 8'h00;
        end
    end

    // Next-state: load a new beat when the output slot frees up; soft reset wins.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_vld_d   = res_vld_q;
        res_d       = res_q;
        dst_d       = dst_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tuser_d     = tuser_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        pkt_count_d = pkt_count_q;
        err_d       = err_q;
        if (load_ok) begin
            state_d   = sel.state;
            cnt_d     = sel.cnt;
            res_vld_d = sel.rest_vld;
            res_d     = sel.rest;
            tvalid_d  = sel.beat;
            tdata_d   = sel.beat ? beat_data : '0;
            tkeep_d   = sel.beat ? beat_keep : '0;
            tlast_d   = sel.beat && sel.tlast;
            tuser_d   = '0;
            if (sel.beat) begin
                tuser_d[TUSER_SRC_LO +: 8] = C_SRC_PORT;
                tuser_d[TUSER_DST_LO +: 8] = sel.beat_new ? sw_dst_port : dst_q;
            end
            if (sel.pkt_new) dst_d = sw_dst_port;
            if (sel.beat && sel.forced) err_d = 1'b1;
        end
        if (tvalid_q && m_axis_tready && tlast_q) pkt_count_d = pkt_count_q + 32'd1;
        if (sw_rst) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            res_vld_d   = 1'b0;
            res_d       = '0;
            dst_d       = '0;
            tdata_d     = '0;
            tkeep_d     = '0;
            tuser_d     = '0;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            pkt_count_d = '0;
            err_d       = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            res_vld_q   <= 1'b0;
            res_q       <= '0;
            dst_q       <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_vld_q   <= res_vld_d;
            res_q       <= res_d;
            dst_q       <= dst_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

    // Ports come straight from registers; the pop strobe is held off in reset.
    always_comb begin
        fifo_rd_en    = pop && rst_n;
        m_axis_tdata  = tdata_q;
        m_axis_tkeep  = tkeep_q;
        m_axis_tuser  = tuser_q;
        m_axis_tvalid = tvalid_q;
        m_axis_tlast  = tlast_q;
        pkt_count     = pkt_count_q;
        err_oversize  = err_q;
    end

endmodule

// File: tb/tb_fifo_to_axis.sv
// Directed bench for fifo_to_axis: FWFT FIFO model, beat capture, immediate
// assertions against hand-computed beats.
module tb_fifo_to_axis;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sw_rst;
    logic [71:0]  fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [7:0]   sw_dst_port;
    logic [31:0]  pkt_count;
    logic         err_oversize;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_to_axis #(
        .C_SRC_PORT  (8'h02),
        .C_MAX_BEATS (190)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rst        (sw_rst),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .sw_dst_port   (sw_dst_port),
        .pkt_count     (pkt_count),
        .err_oversize  (err_oversize)
    );

    // FWFT FIFO model
    logic [71:0] fmem [0:1023];
    logic [9:0]  wr_ptr = '0;
    logic [9:0]  rd_ptr = '0;
    logic        flush  = 1'b0;

    assign fifo_dout  = fmem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 10'd1;
    end

    // Beat capture
    logic [63:0]  acc_data [0:511];
    logic [7:0]   acc_keep [0:511];
    logic         acc_last [0:511];
    logic [127:0] acc_user [0:511];
    int           n_acc = 0;

    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready && n_acc < 512) begin
            acc_data[n_acc] <= m_axis_tdata;
            acc_keep[n_acc] <= m_axis_tkeep;
            acc_last[n_acc] <= m_axis_tlast;
            acc_user[n_acc] <= m_axis_tuser;
            n_acc           <= n_acc + 1;
        end
    end

    function automatic logic [35:0] hv(input logic [31:0] d);
        return {1'b1, 1'b0, 2'b00, d};
    endfunction

    function automatic logic [35:0] he(input logic [1:0] bc, input logic [31:0] d);
        return {1'b1, 1'b1, bc, d};
    endfunction

    function automatic logic [127:0] mk_user(input logic [7:0] dst);
        return {96'h0, dst, 8'h02, 16'h0000};
    endfunction

    task automatic push(input logic [35:0] hi, input logic [35:0] lo);
        fmem[wr_ptr] = {hi, lo};
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [63:0] d,
                              input logic [7:0] k, input logic l, input logic [127:0] u);
        check({tag, "_data"}, 128'(acc_data[idx]), 128'(d));
        check({tag, "_keep"}, 128'(acc_keep[idx]), 128'(k));
        check({tag, "_last"}, 128'(acc_last[idx]), 128'(l));
        check({tag, "_user"}, acc_user[idx], u);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int c = 0;
        while (n_acc < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        assert (n_acc >= target) else begin
            errors++;
            $error("FAIL %s_timeout observed=%0d expected=%0d", tag, n_acc, target);
        end
    endtask

    initial begin
        int         base;
        int         bad;
        logic [9:0] bptr;
        logic [31:0] lo_v;
        logic [31:0] hi_v;

        rst_n         = 1'b0;
        sw_rst        = 1'b0;
        m_axis_tready = 1'b1;
        sw_dst_port   = 8'h10;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
        check("rst_tlast",  128'(m_axis_tlast),  128'(1'b0));
        check("rst_tdata",  128'(m_axis_tdata),  128'(64'h0));
        check("rst_tkeep",  128'(m_axis_tkeep),  128'(8'h0));
        check("rst_tuser",  m_axis_tuser,        128'h0);
        check("rst_pktcnt", 128'(pkt_count),     128'(32'd0));
        check("rst_err",    128'(err_oversize),  128'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: {full,full} then {eop bcnt=3, full}
        base = n_acc;
        push(hv(32'h22222222), hv(32'h11111111));
        push(he(2'd3, 32'h44444444), hv(32'h33333333));
        wait_beats("t1", base + 2, 20);
        check_beat("t1_b0", base,     64'h22222222_11111111, 8'hFF, 1'b0, mk_user(8'h10));
        check_beat("t1_b1", base + 1, 64'h44444444_33333333, 8'hFF, 1'b1, mk_user(8'h10));
        check("t1_pktcnt", 128'(pkt_count), 128'(32'd1));

        // Test 2: low eop bcnt=1, high opens next packet; residue realignment
        sw_dst_port = 8'h20;
        base = n_acc;
        push(hv(32'hBBBBBBBB), he(2'd1, 32'hAAAAAAAA));
        push(he(2'd0, 32'hDDDDDDDD), hv(32'hCCCCCCCC));
        wait_beats("t2", base + 3, 20);
        check_beat("t2_b0", base,     64'h00000000_0000AAAA, 8'h03, 1'b1, mk_user(8'h20));
        check_beat("t2_b1", base + 1, 64'hCCCCCCCC_BBBBBBBB, 8'hFF, 1'b0, mk_user(8'h20));
        check_beat("t2_b2", base + 2, 64'h00000000_000000DD, 8'h01, 1'b1, mk_user(8'h20));
        check("t2_pktcnt", 128'(pkt_count), 128'(32'd3));

        // Test 3: invalid halves skipped; dst changed after packet start
        sw_dst_port = 8'h08;
        base = n_acc;
        push(36'h0, hv(32'h01010101));
        push(hv(32'h02020202), 36'h0);
        push(36'h0, 36'h0);
        push(he(2'd3, 32'h04040404), hv(32'h03030303));
        @(negedge clk);
        sw_dst_port = 8'h80;
        wait_beats("t3", base + 2, 20);
        check_beat("t3_b0", base,     64'h02020202_01010101, 8'hFF, 1'b0, mk_user(8'h08));
        check_beat("t3_b1", base + 1, 64'h04040404_03030303, 8'hFF, 1'b1, mk_user(8'h08));
        check("t3_pktcnt", 128'(pkt_count), 128'(32'd4));
        repeat (3) @(negedge clk);
        check("t3_no_extra", 128'(n_acc), 128'(base + 2));

        // Test 4: tready low for 5 cycles mid-packet
        sw_dst_port = 8'h10;
        base = n_acc;
        bptr = wr_ptr;
        push(hv(32'h10000001), hv(32'h10000000));
        push(hv(32'h10000003), hv(32'h10000002));
        push(he(2'd3, 32'h10000005), hv(32'h10000004));
        @(negedge clk);
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall_tvalid", 128'(m_axis_tvalid), 128'(1'b1));
            check("t4_stall_tdata",  128'(m_axis_tdata),  128'(64'h10000003_10000002));
            check("t4_stall_tkeep",  128'(m_axis_tkeep),  128'(8'hFF));
            check("t4_stall_tuser",  m_axis_tuser,        mk_user(8'h10));
            check("t4_stall_rdptr",  128'(rd_ptr),        128'(bptr + 10'd2));
        end
        m_axis_tready = 1'b1;
        wait_beats("t4", base + 3, 20);
        check_beat("t4_b0", base,     64'h10000001_10000000, 8'hFF, 1'b0, mk_user(8'h10));
        check_beat("t4_b1", base + 1, 64'h10000003_10000002, 8'hFF, 1'b0, mk_user(8'h10));
        check_beat("t4_b2", base + 2, 64'h10000005_10000004, 8'hFF, 1'b1, mk_user(8'h10));
        check("t4_pktcnt", 128'(pkt_count), 128'(32'd5));
        check("t4_err_clear", 128'(err_oversize), 128'(1'b0));

        // Test 5: 200-beat packet truncated at 190, then a clean packet
        sw_dst_port = 8'h01;
        base = n_acc;
        for (int i = 0; i < 200; i++) begin
            lo_v = 32'h50000000 + 32'(2 * i);
            hi_v = lo_v + 32'd1;
            if (i == 199) push(he(2'd3, hi_v), hv(lo_v));
            else          push(hv(hi_v), hv(lo_v));
        end
        push(he(2'd3, 32'h60000001), hv(32'h60000000));
        wait_beats("t5", base + 191, 1000);
        bad = 0;
        for (int j = 0; j < 189; j++) begin
            lo_v = 32'h50000000 + 32'(2 * j);
            hi_v = lo_v + 32'd1;
            if (acc_data[base + j] !== {hi_v, lo_v} || acc_keep[base + j] !== 8'hFF ||
                acc_last[base + j] !== 1'b0)
                bad++;
        end
        check("t5_body_bad", 128'(bad), 128'(0));
        check_beat("t5_b189", base + 189, 64'h5000017B_5000017A, 8'hFF, 1'b1, mk_user(8'h01));
        check_beat("t5_next", base + 190, 64'h60000001_60000000, 8'hFF, 1'b1, mk_user(8'h01));
        check("t5_err", 128'(err_oversize), 128'(1'b1));
        check("t5_pktcnt", 128'(pkt_count), 128'(32'd7));
        repeat (3) @(negedge clk);
        check("t5_no_extra", 128'(n_acc), 128'(base + 191));

        // Test 6: sw_rst mid-packet with a held beat
        m_axis_tready = 1'b0;
        push(hv(32'h70000001), hv(32'h70000000));
        push(he(2'd3, 32'h70000003), hv(32'h70000002));
        @(negedge clk);
        check("t6_held", 128'(m_axis_tvalid), 128'(1'b1));
        sw_rst = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        flush  = 1'b0;
        check("t6_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
        check("t6_tdata",  128'(m_axis_tdata),  128'(64'h0));
        check("t6_pktcnt", 128'(pkt_count),     128'(32'd0));
        check("t6_err",    128'(err_oversize),  128'(1'b0));
        m_axis_tready = 1'b1;
        base = n_acc;
        push(he(2'd1, 32'h88881234), hv(32'h80000000));
        wait_beats("t6", base + 1, 20);
        check_beat("t6_b0", base, 64'h00001234_80000000, 8'h3F, 1'b1, mk_user(8'h01));

        // Test 7: asynchronous rst_n mid-packet
        m_axis_tready = 1'b0;
        push(hv(32'h90000001), hv(32'h90000000));
        push(he(2'd3, 32'h90000003), hv(32'h90000002));
        @(negedge clk);
        check("t7_held", 128'(m_axis_tvalid), 128'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("t7_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
        check("t7_tlast",  128'(m_axis_tlast),  128'(1'b0));
        check("t7_tdata",  128'(m_axis_tdata),  128'(64'h0));
        check("t7_tkeep",  128'(m_axis_tkeep),  128'(8'h0));
        check("t7_tuser",  m_axis_tuser,        128'h0);
        check("t7_pktcnt", 128'(pkt_count),     128'(32'd0));
        check("t7_rd_en",  128'(fifo_rd_en),    128'(1'b0));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        sw_dst_port = 8'h04;
        base = n_acc;
        push(hv(32'hA0000001), hv(32'hA0000000));
        push(he(2'd0, 32'hA00000A3), hv(32'hA0000002));
        wait_beats("t7", base + 2, 20);
        check_beat("t7_b0", base,     64'hA0000001_A0000000, 8'hFF, 1'b0, mk_user(8'h04));
        check_beat("t7_b1", base + 1, 64'h000000A3_A0000002, 8'h1F, 1'b1, mk_user(8'h04));
        check("t7_pktcnt", 128'(pkt_count), 128'(32'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_to_axis.md
# fifo_to_axis

Drains the 72-bit replay FIFO filled by the QDR read stage and re-frames the stored packet stream into a 64-bit AXI4-Stream toward the output port arbiter. Each 72-bit FIFO word is two 36-bit memory halves, each with its own control bits. The block strips invalid padding halves and realigns packets that start mid-word. It also enforces a maximum packet length and drives per-packet tuser metadata. It sits directly downstream of the memory-read stage's FIFO, in the pcap replay micro-engine.

## Interface
- C_FIFO_DATA_WIDTH, 72: FIFO word width; two 36-bit halves, low half = bits [35:0].
- C_M_AXIS_DATA_WIDTH, 64: output tdata width; tkeep is width/8.
- C_M_AXIS_TUSER_WIDTH, 128: output tuser width.
- C_SRC_PORT, 8'h00: one-hot source-port code placed in tuser[23:16].
- C_MAX_BEATS, 190: maximum beats per packet before forced truncation.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- sw_rst  in  1  synchronous soft reset; same effect as rst_n.
- fifo_dout  in  72  first-word-fall-through FIFO head.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pop strobe; valid only when !fifo_empty.
- m_axis_tdata  out  64
- m_axis_tkeep  out  8
- m_axis_tuser  out  128
- m_axis_tvalid  out  1
- m_axis_tlast  out  1
- m_axis_tready  in  1
- sw_dst_port  in  8  one-hot destination code placed in tuser[31:24]; sampled at packet start.
- pkt_count  out  32  packets emitted (tlast beats accepted); wraps.
- err_oversize  out  1  sticky; set on truncation.

## Operation
- Half format: [35] valid, [34] eop, [33:32] byte count minus 1 (meaningful only when eop), [31:0] payload. Byte 0 is at [7:0]. The start of a packet is implicit: it is the first valid half after reset or after an eop.
- Processing order: residue half (if any), then FIFO low half, then FIFO high half. Halves with valid=0 are discarded.
- Beat assembly: the first half goes to tdata[31:0], the second to [63:32]. A beat is emitted when 2 halves are collected or an eop half is placed.
- tkeep: a full half sets 4 bits. An eop half sets count+1 bits, lowest lanes first, in its lane group. Unused lanes are 0, and their tdata is 0.
- Residue: a 1-half register. It holds one leftover half when a word cannot complete a beat, or when the half is the first half of the next packet.
- At most one beat is emitted per cycle. A word is popped only if all its halves fit: at most one beat plus at most one half left in residue.
- If the residue holds an eop half, it is emitted alone with tlast. No pop occurs that cycle.
- tuser: [15:0] = 0, [23:16] = C_SRC_PORT, [31:24] = sw_dst_port latched at the first half of the packet, upper bits = 0. tuser is constant for the whole packet.
- FSM:
  - IDLE: no packet open. Go to PKT on the first valid half.
  - PKT: go to IDLE on the eop beat accepted. Go to DROP when the C_MAX_BEATS-th beat is emitted without eop; that beat is forced tlast and sets err_oversize.
  - DROP: pop and discard halves up to and including the next eop half. Halves after that eop in the same word are processed normally. Then go to IDLE.
- pkt_count increments on each accepted beat with tvalid, tready and tlast, including forced-tlast beats.

## Timing
- Reset values: fifo_rd_en 0, tvalid 0, tlast 0, tdata/tkeep/tuser 0, pkt_count 0, err_oversize 0, residue empty, FSM IDLE.
- All AXIS outputs are registered. A beat appears on the cycle after the pop that supplies it.
- AXIS rule: once tvalid is high, tdata, tkeep, tuser and tlast hold until tready is seen.
- Pop condition: output register empty, or being accepted this cycle, and the rule above satisfied.
- Sustained throughput: one word per cycle when all halves are valid and tready is held high.
- A pending residue never blocks the pop of a word that completes a beat with it.
- sw_rst or rst_n mid-packet discards the residue and the held beat immediately. No tlast is emitted for the aborted packet.

## Structure
- Shared include file: half-format bit positions (VALID_BIT, EOP_BIT, BCNT_HI/LO), the tuser field offsets, and the FSM state encodings. The memory-write stage reuses these.
- One natural sub-module: `half_keep_gen`, which maps (valid, eop, bcnt) to a 4-bit keep. It is instantiated for both lane groups.

## Test plan
- Two words {full, full} then {eop bcnt=3, full} -> beats: tkeep FF, then FF with tlast; pkt_count=1.
- Word with low=eop bcnt=1 and high=valid (next packet) -> beat tkeep 03, tlast. The next packet's first beat has the held half in [31:0].
- Words containing valid=0 halves between packets -> no empty beats; data is contiguous across skipped halves.
- tready low for 5 cycles mid-packet -> tdata, tkeep and tuser stable; no pops; no data lost.
- 200-beat packet with C_MAX_BEATS=190 -> the 190th beat has tlast and err_oversize=1. The remaining halves are dropped, and the next packet is emitted intact.
- rst_n asserted mid-packet while tvalid is high -> all outputs return to reset values asynchronously. The first packet after release is correct.
